// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M issue controller.
//   - OP_MUL..OP_REMU: 5-bit op codes presented on ex_op_sel / md_op_sel
//   - md_state_e     : issue controller FSM state encoding
//   - is_m_op()      : range check for the M-extension op space (5'b10xxx)
package rv32m_pkg;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } md_state_e;

    function automatic logic is_m_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/rv32m_result_cache.sv
// rv32m_result_cache: one-entry memo of the last completed mul/div op.
// Only built when RV32M_RESULT_CACHE_EN is defined.
// Ports:
//   clk, rst_n                 clock, async active-low reset (clears valid)
//   lk_op/lk_rs1/lk_rs2        lookup key (live EX operands)
//   hit, hit_data              key matches the stored entry, stored result
//   wr_en                      store a completed op
//   wr_op/wr_rs1/wr_rs2/wr_result  entry contents to store
`ifdef RV32M_RESULT_CACHE_EN
module rv32m_result_cache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  lk_op,
    input  logic [31:0] lk_rs1,
    input  logic [31:0] lk_rs2,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_op,
    input  logic [31:0] wr_rs1,
    input  logic [31:0] wr_rs2,
    input  logic [31:0] wr_result
);

    logic        valid_q;
    logic [4:0]  op_q;
    logic [31:0] rs1_q, rs2_q, res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
            op_q    <= wr_op;
            rs1_q   <= wr_rs1;
            rs2_q   <= wr_rs2;
            res_q   <= wr_result;
        end
    end

    assign hit      = valid_q & (lk_op == op_q) & (lk_rs1 == rs1_q) & (lk_rs2 == rs2_q);
    assign hit_data = res_q;

endmodule
`endif

// File: rtl/rv32m_issue_ctrl.sv
// rv32m_issue_ctrl: pipeline-side initiator for the multicycle RV32M unit.
// Accepts an M op from EX, stalls the pipeline, issues one md_op_valid pulse,
// waits for md_done and writes the result back for one cycle. A flush while
// the unit is busy drains the outstanding result; a watchdog aborts a WAIT or
// DRAIN that never sees md_done.
// Optional: define RV32M_RESULT_CACHE_EN to add a one-entry result cache that
// short-circuits repeated ops straight to writeback.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ex_valid/ex_op_sel/ex_rs1/ex_rs2/ex_rd/ex_tag   candidate op from EX
//   flush                            kill the in-flight M op
//   stall                            hold front-end/EX
//   md_op_valid/md_op_sel/md_rs1/md_rs2   request to the mul/div unit
//   md_busy/md_done/md_result        unit status and result
//   wb_valid/wb_rd/wb_data/wb_tag    one-cycle writeback
//   err_timeout                      watchdog pulse
module rv32m_issue_ctrl
    import rv32m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 96,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [4:0]       ex_op_sel,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic [TAG_W-1:0] ex_tag,
    input  logic             flush,
    output logic             stall,
    output logic             md_op_valid,
    output logic [4:0]       md_op_sel,
    output logic [31:0]      md_rs1,
    output logic [31:0]      md_rs2,
    input  logic             md_busy,
    input  logic             md_done,
    input  logic [31:0]      md_result,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    md_state_e        state, state_nxt;
    logic [4:0]       op_q, rd_q;
    logic [31:0]      rs1_q, rs2_q, res_q;
    logic [TAG_W-1:0] tag_q;
    logic [WD_W-1:0]  wdog;

    logic        is_m, accept, hit, wd_fire;
    logic [31:0] hit_data;

    // Completion is signalled by md_done alone; busy is not needed.
    logic unused_busy;
    assign unused_busy = md_busy;

    assign is_m   = ex_valid & is_m_op(ex_op_sel);
    assign accept = (state == ST_IDLE) & is_m & ~flush;

    // A flush in WAIT moves to DRAIN (fresh count), so it masks the watchdog.
    // A done arriving in the last allowed cycle still wins over the timeout.
    assign wd_fire = (wdog == WD_W'(TIMEOUT_CYCLES - 1)) & ~md_done &
                     (((state == ST_WAIT) & ~flush) | (state == ST_DRAIN));

`ifdef RV32M_RESULT_CACHE_EN
    logic cache_wr;
    assign cache_wr = (state == ST_WAIT) & md_done & ~flush;

    rv32m_result_cache u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_op     (ex_op_sel),
        .lk_rs1    (ex_rs1),
        .lk_rs2    (ex_rs2),
        .hit       (hit),
        .hit_data  (hit_data),
        .wr_en     (cache_wr),
        .wr_op     (op_q),
        .wr_rs1    (rs1_q),
        .wr_rs2    (rs2_q),
        .wr_result (md_result)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = hit ? ST_WB : ST_ISSUE;
            // The request pulse has already gone out; a flush must drain it.
            ST_ISSUE: state_nxt = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                // done together with flush: result is here, just drop it.
                if (md_done)      state_nxt = flush ? ST_IDLE : ST_WB;
                else if (flush)   state_nxt = ST_DRAIN;
                else if (wd_fire) state_nxt = ST_IDLE;
            end
            ST_WB:    state_nxt = ST_IDLE;
            ST_DRAIN: if (md_done | wd_fire) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            tag_q <= '0;
            res_q <= '0;
            wdog  <= '0;
        end else begin
            if (accept) begin
                op_q  <= ex_op_sel;
                rs1_q <= ex_rs1;
                rs2_q <= ex_rs2;
                rd_q  <= ex_rd;
                tag_q <= ex_tag;
                if (hit) res_q <= hit_data;
            end
            if ((state == ST_WAIT) & md_done) res_q <= md_result;
            // Any state change clears the count, so WAIT/DRAIN start at 0.
            if (state_nxt != state)
                wdog <= '0;
            else if ((state == ST_WAIT) | (state == ST_DRAIN))
                wdog <= wdog + 1'b1;
        end
    end

    // WB releases the pipeline so the next op can present in the following cycle.
    assign stall       = ((state != ST_IDLE) & (state != ST_WB)) | (is_m & (state == ST_IDLE));
    assign md_op_valid = (state == ST_ISSUE);
    assign md_op_sel   = op_q;
    assign md_rs1      = rs1_q;
    assign md_rs2      = rs2_q;
    assign wb_valid    = (state == ST_WB) & (rd_q != 5'd0);
    assign wb_rd       = rd_q;
    assign wb_data     = res_q;
    assign wb_tag      = tag_q;
    assign err_timeout = wd_fire;

endmodule

// File: tb/tb_rv32m_issue_ctrl.sv
// Directed bench for rv32m_issue_ctrl with a behavioural mul/div unit model
// (programmable done latency, or never-done) and a writeback scoreboard.
module tb_rv32m_issue_ctrl;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_op_sel = '0;
    logic [31:0] ex_rs1 = '0, ex_rs2 = '0;
    logic [4:0]  ex_rd = '0;
    logic [3:0]  ex_tag = '0;
    logic        flush = 1'b0;
    logic        stall, md_op_valid;
    logic [4:0]  md_op_sel;
    logic [31:0] md_rs1, md_rs2;
    logic        md_busy;
    logic        md_done = 1'b0;
    logic [31:0] md_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  wb_tag;
    logic        err_timeout;

    rv32m_issue_ctrl #(.TIMEOUT_CYCLES(96), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op_sel(ex_op_sel),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_tag(ex_tag),
        .flush(flush), .stall(stall), .md_op_valid(md_op_valid),
        .md_op_sel(md_op_sel), .md_rs1(md_rs1), .md_rs2(md_rs2),
        .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_tag(wb_tag),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- mul/div unit model ----------------
    function automatic logic [31:0] md_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (op)
            OP_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
            OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            OP_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                       else return $signed(a) / $signed(b);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    if (b == 0) return a;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                       else return $signed(a) % $signed(b);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    int lat  = 1;    // WAIT cycle (1-based) in which done arrives
    bit hang = 1'b0; // unit never answers
    int ucnt = 0;
    assign md_busy = (ucnt != 0);

    always @(posedge clk) begin
        md_done <= 1'b0;
        if (md_op_valid) begin
            if (!hang) begin
                if (lat <= 1) begin
                    md_done   <= 1'b1;
                    md_result <= md_calc(md_op_sel, md_rs1, md_rs2);
                    ucnt      <= 0;
                end else ucnt <= lat - 1;
            end
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) begin
                md_done   <= 1'b1;
                // Live request lines: they must still hold the operands.
                md_result <= md_calc(md_op_sel, md_rs1, md_rs2);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t sb[$];

    int iss_cnt = 0, tmo_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (md_op_valid) iss_cnt++;
        if (err_timeout) tmo_cnt++;
        if (md_done)     done_cnt++;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {27'd0, wb_rd}, 32'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd",   {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_tag",  {28'd0, wb_tag}, {28'd0, e.tag});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    // Present one op, hold it while stalled, and measure cycles from accept
    // (cycle 1) until stall releases in WB or the watchdog fires.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [3:0] tag, input logic exp_wb,
                          input logic [31:0] exp_data, input int exp_lat, input int exp_iss,
                          input int exp_tmo, input string name);
        int cyc, iss0, tmo0;
        wb_exp_t e;
        @(negedge clk);
        ex_op_sel = op; ex_rs1 = a; ex_rs2 = b; ex_rd = rd; ex_tag = tag; ex_valid = 1'b1;
        iss0 = iss_cnt; tmo0 = tmo_cnt;
        if (exp_wb) begin
            e.rd = rd; e.tag = tag; e.data = exp_data;
            sb.push_back(e);
        end
        #1 chk({name, "_stall_accept"}, {31'd0, stall}, 32'd1);
        cyc = 1;
        while (cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (stall === 1'b0 || err_timeout === 1'b1) break;
        end
        ex_valid = 1'b0;
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_issues"}, iss_cnt - iss0, exp_iss);
        chk({name, "_timeouts"}, tmo_cnt - tmo0, exp_tmo);
    endtask

    initial begin
        int k, iss0, done0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_opv",    {31'd0, md_op_valid}, 32'd0);
        chk("rst_wbv",    {31'd0, wb_valid}, 32'd0);
        chk("rst_tmo",    {31'd0, err_timeout}, 32'd0);
        chk("rst_md_rs1", md_rs1, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        rst_n = 1'b1;

        lat = 5; run_op(OP_MUL,  32'd7,   32'd6, 5'd5, 4'd3, 1'b1, 32'd42, 8, 1, 0, "mul");
        lat = 1; run_op(OP_DIVU, 32'd100, 32'd0, 5'd6, 4'd4, 1'b1, 32'hFFFF_FFFF, 4, 1, 0, "divu0");
        lat = 1; run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 4'd5, 1'b1, 32'h8000_0000, 4, 1, 0, "div_ovf");
        lat = 2; run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 4'd6, 1'b1, 32'd0, 5, 1, 0, "rem_ovf");

        // Flush 5 cycles into WAIT: stall held until the late done is drained
        lat = 20;
        @(negedge clk);
        ex_op_sel = OP_MULHU; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'hFFFF_FFFF;
        ex_rd = 5'd9; ex_tag = 4'd7; ex_valid = 1'b1;
        iss0 = iss_cnt; done0 = done_cnt;
        repeat (6) @(negedge clk);
        flush = 1'b1; ex_valid = 1'b0;
        k = 0;
        while (k < 200) begin
            @(negedge clk); #1;
            flush = 1'b0;
            k++;
            if (stall === 1'b0) break;
        end
        chk("flush_wait_release", k, 16);
        chk("flush_wait_drained", done_cnt - done0, 1);
        chk("flush_wait_issues",  iss_cnt - iss0, 1);

        lat = 1; run_op(OP_MUL, 32'd3, 32'd3, 5'd10, 4'd8, 1'b1, 32'd9, 4, 1, 0, "mul_after_flush");

        // Lost done: watchdog fires in the 96th WAIT cycle, no writeback
        hang = 1'b1;
        run_op(OP_MUL, 32'd11, 32'd13, 5'd11, 4'd9, 1'b0, 32'd0, 98, 1, 1, "timeout");
        hang = 1'b0;
        @(negedge clk); #1;
        chk("timeout_idle", {31'd0, stall}, 32'd0);

        lat = 1; run_op(OP_MUL, 32'd2, 32'd2, 5'd0, 4'd1, 1'b0, 32'd0, 4, 1, 0, "rd0");

        // Flush in the candidate cycle blocks acceptance
        @(negedge clk);
        ex_op_sel = OP_MUL; ex_rs1 = 32'd4; ex_rs2 = 32'd4; ex_rd = 5'd12; ex_valid = 1'b1; flush = 1'b1;
        iss0 = iss_cnt;
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("flush_idle_issues", iss_cnt - iss0, 0);
        chk("flush_idle_stall",  {31'd0, stall}, 32'd0);

        // Flush in ISSUE: request still goes out, then drained
        lat = 3;
        @(negedge clk);
        ex_op_sel = OP_MUL; ex_rs1 = 32'd5; ex_rs2 = 32'd5; ex_rd = 5'd13; ex_valid = 1'b1;
        iss0 = iss_cnt;
        @(negedge clk); #1;
        chk("flush_issue_opv", {31'd0, md_op_valid}, 32'd1);
        flush = 1'b1; ex_valid = 1'b0;
        k = 0;
        while (k < 200) begin
            @(negedge clk); #1;
            flush = 1'b0;
            k++;
            if (stall === 1'b0) break;
        end
        chk("flush_issue_release", k, 4);
        chk("flush_issue_issues",  iss_cnt - iss0, 1);

        // Reset mid-operation: back to IDLE at once, late done is ignored
        lat = 10;
        @(negedge clk);
        ex_op_sel = OP_DIVU; ex_rs1 = 32'd50; ex_rs2 = 32'd5; ex_rd = 5'd14; ex_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_opv",   {31'd0, md_op_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Same op twice, back to back
        lat = 3;
        run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 5'd15, 4'd10, 1'b1, 32'hFFFF_FFFF, 6, 1, 0, "mulh_1");
`ifdef RV32M_RESULT_CACHE_EN
        run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 5'd16, 4'd11, 1'b1, 32'hFFFF_FFFF, 2, 0, 0, "mulh_hit");
`else
        run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 5'd16, 4'd11, 1'b1, 32'hFFFF_FFFF, 6, 1, 0, "mulh_2");
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
